// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared receiver state encoding and frame constants
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } ERxState;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 108;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo : first-word fall-through byte FIFO with occupancy count
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             read_data,
  output logic                          read_valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign read_valid = (count_q != '0);
  assign full       = (count_q == DEPTH_C);
  assign count      = count_q;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign read_data  = read_valid ? mem_q[rd_ptr_q] : '0;

  assign do_pop  = pop && read_valid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver : 8N1 deserialiser feeding a byte FIFO, with rtr flow control
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       rtr,
  output logic [7:0] read_data,
  output logic       read_valid,
  input  logic       read_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]      BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [CNT_W-1:0] RTR_LIMIT = CNT_W'(FIFO_DEPTH - 1);

  logic             rx_meta_q, rx_s_q;
  ERxState          state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             rtr_q, rtr_d;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  assign state         = state_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign rtr           = rtr_q;

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (UART_DATA_BITS)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push_q),
    .push_data  (shift_q),
    .pop        (read_ready),
    .read_data  (read_data),
    .read_valid (read_valid),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A completed byte only overruns if the consumer is not freeing a slot this cycle.
  assign ov_d  = push_q && fifo_full && !(read_ready && read_valid);
  assign rtr_d = (fifo_count < RTR_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      rtr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      rtr_q     <= rtr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_receiver : scoreboard bench for uart_receiver (16 clks/bit, depth 4)
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       rtr;
  logic [7:0] read_data;
  logic       read_valid;
  logic       read_ready;
  logic       framing_error;
  logic       overrun;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
  } vec_t;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .rtr           (rtr),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .read_ready    (read_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .state         (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic expect_push);
    if (expect_push) sb.push_back(d);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic drain(input string name);
    int n;
    read_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || read_valid) && n < 50) begin
      tick(1);
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
  endtask

  // Pops compare against the scoreboard; pulses are tallied for the sequences.
  always @(negedge clock) begin
    if (reset_n) begin
      if (read_valid && read_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", read_data);
        end else begin
          check("read_data", {24'd0, read_data}, {24'd0, sb.pop_front()});
        end
      end
      if (framing_error && overrun) check("fe_ov_exclusive", 32'd1, 32'd0);
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   fe_base, ov_base;

    vecs[0] = '{8'hF0, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h5A, 1'b0};
    vecs[4] = '{8'h81, 1'b1};
    vecs[5] = '{8'hA5, 1'b1};

    reset_n    = 1'b0;
    rx         = 1'b1;
    read_ready = 1'b0;
    tick(3);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_valid", {31'd0, read_valid}, 32'd0);
    check("rst_data", {24'd0, read_data}, 32'd0);
    check("rst_rtr", {31'd0, rtr}, 32'd0);
    check("rst_pulses", {30'd0, framing_error, overrun}, 32'd0);
    reset_n = 1'b1;
    tick(3);
    check("rtr_after_rst", {31'd0, rtr}, 32'd1);

    // Single frames with read_ready tied high
    read_ready = 1'b1;
    foreach (vecs[i]) begin
      fe_base = fe_cnt;
      send_byte(vecs[i].data, vecs[i].stop_bit, vecs[i].stop_bit);
      tick(4);
      check("vec_fe", fe_cnt - fe_base, {31'd0, ~vecs[i].stop_bit});
      check("vec_state", {29'd0, state}, 32'd0);
      check("vec_delivered", sb.size(), 0);
    end

    // Back-pressure: three held bytes close rtr
    read_ready = 1'b0;
    send_byte(8'h12, 1'b1, 1'b1);
    send_byte(8'h34, 1'b1, 1'b1);
    check("rtr_two_held", {31'd0, rtr}, 32'd1);
    send_byte(8'h56, 1'b1, 1'b1);
    check("rtr_three_held", {31'd0, rtr}, 32'd0);
    check("valid_held", {31'd0, read_valid}, 32'd1);
    check("head_held", {24'd0, read_data}, 32'h12);
    drain("bp");
    tick(2);
    check("rtr_reopened", {31'd0, rtr}, 32'd1);

    // Overrun on the fifth byte
    read_ready = 1'b0;
    ov_base = ov_cnt;
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1, 1'b1);
    check("ov_none_at_full", ov_cnt - ov_base, 0);
    send_byte(8'h05, 1'b1, 1'b0);
    check("ov_once", ov_cnt - ov_base, 1);
    drain("ov");

    // Framing error then recovery
    fe_base = fe_cnt;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = 8'hA5 >> i;
      tick(CPB);
    end
    rx = 1'b0;
    tick(2 * CPB);
    check("fe_pulse", fe_cnt - fe_base, 1);
    check("wait_idle", {29'd0, state}, 32'd4);
    check("fe_no_push", {31'd0, read_valid}, 32'd0);
    rx = 1'b1;
    tick(6);
    check("fe_to_idle", {29'd0, state}, 32'd0);
    send_byte(8'h3C, 1'b1, 1'b1);
    drain("fe");

    // Start-bit glitch
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    rx = 1'b0;
    tick(4);
    check("glitch_start", {29'd0, state}, 32'd1);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_idle", {29'd0, state}, 32'd0);
    check("glitch_pulses", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);
    check("glitch_no_push", {31'd0, read_valid}, 32'd0);

    // Reset during DATA with a byte already held
    read_ready = 1'b0;
    send_byte(8'h77, 1'b1, 1'b0);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    check("pre_rst_data_state", {29'd0, state}, 32'd2);
    check("pre_rst_valid", {31'd0, read_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_valid", {31'd0, read_valid}, 32'd0);
    check("midrst_data", {24'd0, read_data}, 32'd0);
    check("midrst_rtr", {31'd0, rtr}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    read_ready = 1'b1;
    send_byte(8'h55, 1'b1, 1'b1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
